// File: rtl/bottom_sorter_pkg.sv
// bottom_sorter_pkg: shared sizing constants and lane-vector type for the 4-lane sorter
package bottom_sorter_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int LANES = 4;
  localparam int STAGES = 4;
  typedef logic [LANES-1:0][DEFAULT_WIDTH-1:0] lanes_t;
endpackage

// File: rtl/bottom_sorter_cas.sv
// bottom_sorter_cas: combinational compare-exchange, swaps only when a > b (equal values keep order)
// ports: a, b in; lo = min, hi = max
module bottom_sorter_cas import bottom_sorter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  always_comb begin
    lo = a > b ? b : a;
    hi = a > b ? a : b;
  end
endmodule

// File: rtl/bottom_sorter.sv
// bottom_sorter: 4-stage pipelined odd-even transposition sorter, o1 smallest .. o4 largest
// ports: clk, rst_n (async active-low), i1..i4 in, o1..o4 out (registered, latency 4 edges)
// BOTTOM_SORTER_VALID_EN adds in_valid/out_valid; data stages then update only on incoming valid
module bottom_sorter import bottom_sorter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef BOTTOM_SORTER_VALID_EN
  input  logic             in_valid,
  output logic             out_valid,
`endif
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4
);
  logic [LANES-1:0][WIDTH-1:0] s1, s2, s3, s4, n1, n2, n3, n4;
  logic [STAGES-1:0] en;
`ifdef BOTTOM_SORTER_VALID_EN
  logic [STAGES-1:0] v;
  assign en = {v[STAGES-2:0], in_valid};
  assign out_valid = v[STAGES-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else v <= {v[STAGES-2:0], in_valid};
`else
  assign en = '1;
`endif
  bottom_sorter_cas #(.WIDTH(WIDTH)) c1a (.a(i1),    .b(i2),    .lo(n1[0]), .hi(n1[1]));
  bottom_sorter_cas #(.WIDTH(WIDTH)) c1b (.a(i3),    .b(i4),    .lo(n1[2]), .hi(n1[3]));
  bottom_sorter_cas #(.WIDTH(WIDTH)) c2  (.a(s1[1]), .b(s1[2]), .lo(n2[1]), .hi(n2[2]));
  bottom_sorter_cas #(.WIDTH(WIDTH)) c3a (.a(s2[0]), .b(s2[1]), .lo(n3[0]), .hi(n3[1]));
  bottom_sorter_cas #(.WIDTH(WIDTH)) c3b (.a(s2[2]), .b(s2[3]), .lo(n3[2]), .hi(n3[3]));
  bottom_sorter_cas #(.WIDTH(WIDTH)) c4  (.a(s3[1]), .b(s3[2]), .lo(n4[1]), .hi(n4[2]));
  assign n2[0] = s1[0];
  assign n2[3] = s1[3];
  assign n4[0] = s3[0];
  assign n4[3] = s3[3];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
    end else begin
      if (en[0]) s1 <= n1;
      if (en[1]) s2 <= n2;
      if (en[2]) s3 <= n3;
      if (en[3]) s4 <= n4;
    end
  assign o1 = s4[0];
  assign o2 = s4[1];
  assign o3 = s4[2];
  assign o4 = s4[3];
endmodule

// File: tb/tb_bottom_sorter.sv
// tb_bottom_sorter: scoreboard bench, driver pushes hand-computed sorted sets, monitor pops at output time
module tb_bottom_sorter;
  logic clk = 0;
  logic rst_n = 1;
  logic [3:0] i1 = 0, i2 = 0, i3 = 0, i4 = 0;
  logic [3:0] o1, o2, o3, o4;
  logic [3:0] tag = '0;
  logic trk = 0;
  logic [15:0] q[$];
  int errors = 0;
  int checks = 0;

  bottom_sorter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tag <= '0;
    else tag <= {tag[2:0], trk};

  task automatic step(input logic r, input logic [3:0] a, b, c, d, input logic [15:0] e);
    @(negedge clk);
    rst_n = r;
    trk = r;
    i1 = a; i2 = b; i3 = c; i4 = d;
    if (!r) q.delete();
    else q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [15:0] got, exp;
    #1;
    got = {o1, o2, o3, o4};
    checks++;
    if (!rst_n || !tag[3]) begin
      if (got !== 16'h0) begin
        errors++;
        $display("FAIL idle_zero: got %h required 0000", got);
      end
    end else if (q.size() == 0) begin
      errors++;
      $display("FAIL underflow: output %h with no expected set", got);
    end else begin
      exp = q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL sorted: got %h required %h", got, exp);
      end
    end
  end

  initial begin
    #1 rst_n = 0;
    repeat (3) step(0, 9, 5, 12, 3, 0);
    step(1, 6, 2, 4, 1, 16'h1246);
    repeat (4) step(1, 0, 0, 0, 0, 16'h0000);
    step(1, 15, 14, 13, 12, 16'hCDEF);
    step(1, 0, 5, 9, 15, 16'h059F);
    step(1, 3, 3, 0, 3, 16'h0333);
    step(1, 7, 7, 7, 7, 16'h7777);
    step(1, 1, 2, 3, 0, 16'h0123);
    step(1, 4, 3, 2, 1, 16'h1234);
    step(1, 6, 2, 4, 1, 16'h1246);
    step(1, 9, 8, 0, 15, 16'h089F);
    step(1, 1, 1, 2, 0, 16'h0112);
    step(1, 13, 1, 7, 4, 16'h147D);
    step(1, 2, 11, 5, 8, 16'h258B);
    step(0, 15, 15, 15, 15, 16'h0000);
    step(0, 14, 10, 6, 9, 16'h0000);
    step(1, 5, 3, 9, 1, 16'h1359);
    step(1, 10, 0, 10, 2, 16'h02AA);
    repeat (3) step(1, 0, 0, 0, 0, 16'h0000);
    @(negedge clk);
    trk = 0;
    i1 = 0; i2 = 0; i3 = 0; i4 = 0;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d sets still pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
